// File: rtl/logic_ni_rx.sv
// Receive NI: pops HEAD/BODY/TAIL flits, reassembles a 24-bit sample and writes it to {src, osc}.
// Write is presented the cycle after the TAIL pop and held until WrReady_i; no pops while a write is pending.
module logic_ni_rx #(
    parameter int NumOsc      = 25,
    parameter int ErrCntWidth = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   FifoEmpty_i,
    input  logic [31:0]            FifoRdData_i,
    output logic                   FifoRd_o,
    output logic                   Wr_o,
    input  logic                   WrReady_i,
    output logic [8:0]             WrAddr_o,
    output logic [23:0]            WrData_o,
    output logic                   FrameDone_o,
    output logic [3:0]             FrameSrc_o,
    output logic [ErrCntWidth-1:0] ErrCnt_o,
    output logic                   Busy_o
);

    typedef enum logic [1:0] {S_HEAD, S_BODY, S_TAIL, S_WRITE} state_t;

    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_BODY = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b11;
    localparam logic [4:0] LAST_OSC = 5'(NumOsc - 1);

    state_t                   r_state;
    state_t                   w_next;
    logic [3:0]               r_src;
    logic [4:0]               r_osc;
    logic                     r_drop;
    logic [15:0]              r_hi;
    logic                     r_wr;
    logic [8:0]               r_wr_addr;
    logic [23:0]              r_wr_data;
    logic                     r_frame_done;
    logic [3:0]               r_frame_src;
    logic [ErrCntWidth-1:0]   r_err;

    logic       w_pop;
    logic       w_busy;
    logic [1:0] w_type;
    logic       w_oob;
    logic       w_accept;
    logic       w_err_inc;
    logic       w_latch_hdr;
    logic       w_latch_body;
    logic       w_do_write;
    logic       w_unused;

    assign w_type   = FifoRdData_i[31:30];
    assign w_oob    = FifoRdData_i[4:0] > LAST_OSC;
    assign w_accept = (r_state == S_WRITE) & WrReady_i;
    assign w_unused = ^FifoRdData_i[29:16];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_HEAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_err_inc    = 1'b0;
        w_latch_hdr  = 1'b0;
        w_latch_body = 1'b0;
        w_do_write   = 1'b0;
        case (r_state)
            S_HEAD: begin
                if (w_pop) begin
                    if (w_type == T_HEAD) begin
                        w_latch_hdr = 1'b1;
                        w_err_inc   = w_oob;
                        w_next      = S_BODY;
                    end else begin
                        w_err_inc = 1'b1;
                    end
                end
            end
            S_BODY: begin
                if (w_pop) begin
                    if (w_type == T_BODY) begin
                        w_latch_body = 1'b1;
                        w_next       = S_TAIL;
                    end else if (w_type == T_HEAD) begin
                        w_latch_hdr = 1'b1;
                        w_err_inc   = 1'b1;
                        w_next      = S_BODY;
                    end else begin
                        w_err_inc = 1'b1;
                        w_next    = S_HEAD;
                    end
                end
            end
            S_TAIL: begin
                if (w_pop) begin
                    if (w_type == T_TAIL) begin
                        w_do_write = ~r_drop;
                        w_next     = r_drop ? S_HEAD : S_WRITE;
                    end else if (w_type == T_HEAD) begin
                        w_latch_hdr = 1'b1;
                        w_err_inc   = 1'b1;
                        w_next      = S_BODY;
                    end else begin
                        w_err_inc = 1'b1;
                        w_next    = S_HEAD;
                    end
                end
            end
            default: begin
                if (WrReady_i) begin
                    w_next = S_HEAD;
                end
            end
        endcase
    end

    always_comb begin
        w_pop  = ~FifoEmpty_i & (r_state != S_WRITE);
        w_busy = (r_state != S_HEAD);
    end

    // Header fields and the drop flag; a resync HEAD re-evaluates the drop flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src  <= '0;
            r_osc  <= '0;
            r_drop <= 1'b0;
            r_hi   <= '0;
        end else begin
            if (w_latch_hdr) begin
                r_src  <= FifoRdData_i[8:5];
                r_osc  <= FifoRdData_i[4:0];
                r_drop <= w_oob;
            end else if (w_next == S_HEAD) begin
                r_drop <= 1'b0;
            end
            if (w_latch_body) begin
                r_hi <= FifoRdData_i[15:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr         <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_frame_done <= 1'b0;
            r_frame_src  <= '0;
        end else begin
            if (w_do_write) begin
                r_wr      <= 1'b1;
                r_wr_addr <= {r_src, r_osc};
                r_wr_data <= {r_hi, FifoRdData_i[7:0]};
            end else if (w_accept) begin
                r_wr <= 1'b0;
            end
            r_frame_done <= w_accept & (r_wr_addr[4:0] == LAST_OSC);
            if (w_accept & (r_wr_addr[4:0] == LAST_OSC)) begin
                r_frame_src <= r_wr_addr[8:5];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= '0;
        end else if (w_err_inc && (r_err != {ErrCntWidth{1'b1}})) begin
            r_err <= r_err + ErrCntWidth'(1);
        end
    end

    assign FifoRd_o    = w_pop;
    assign Busy_o      = w_busy;
    assign Wr_o        = r_wr;
    assign WrAddr_o    = r_wr_addr;
    assign WrData_o    = r_wr_data;
    assign FrameDone_o = r_frame_done;
    assign FrameSrc_o  = r_frame_src;
    assign ErrCnt_o    = r_err;

endmodule

// File: tb/tb_logic_ni_rx.sv
// Bench for logic_ni_rx: queue-backed ingress FIFO, packet-level reference model, per-cycle compare.
module tb_logic_ni_rx;

    localparam int NOSC = 25;

    logic        clk = 1'b0;
    logic        rst;
    logic        FifoEmpty_i;
    logic [31:0] FifoRdData_i;
    logic        WrReady_i;
    logic        FifoRd_o;
    logic        Wr_o;
    logic [8:0]  WrAddr_o;
    logic [23:0] WrData_o;
    logic        FrameDone_o;
    logic [3:0]  FrameSrc_o;
    logic [7:0]  ErrCnt_o;
    logic        Busy_o;

    logic_ni_rx #(.NumOsc(NOSC), .ErrCntWidth(8)) dut (
        .clk(clk), .rst(rst),
        .FifoEmpty_i(FifoEmpty_i), .FifoRdData_i(FifoRdData_i), .FifoRd_o(FifoRd_o),
        .Wr_o(Wr_o), .WrReady_i(WrReady_i), .WrAddr_o(WrAddr_o), .WrData_o(WrData_o),
        .FrameDone_o(FrameDone_o), .FrameSrc_o(FrameSrc_o),
        .ErrCnt_o(ErrCnt_o), .Busy_o(Busy_o)
    );

    always #5 clk = ~clk;

    logic [31:0] fifo_q[$];
    logic [32:0] wr_log[$];
    int  rdy_pct  = 100;
    bit  rdy_hold = 1'b0;
    bit  rd_seen  = 1'b0;
    int  fd_cnt   = 0;
    int  wr_cyc   = 0;
    logic [3:0] last_fsrc = '0;
    int  n_checks = 0;
    int  n_errors = 0;

    // Reference model: packet-parse progress plus the pending write.
    bit          m_hdr = 0, m_body = 0, m_drop = 0, m_pend = 0, m_fd = 0;
    logic [3:0]  m_src = '0, m_fsrc = '0;
    logic [4:0]  m_osc = '0;
    logic [15:0] m_hi = '0;
    logic [8:0]  m_addr = '0;
    logic [23:0] m_data = '0;
    int          m_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void bump();
        if (m_err < 255) m_err++;
    endfunction

    function automatic void model_flit(input logic [31:0] f);
        logic [1:0] t;
        t = f[31:30];
        case (t)
            2'b00: begin
                if (m_hdr || (f[4:0] >= NOSC)) bump();
                m_hdr = 1; m_body = 0;
                m_src = f[8:5]; m_osc = f[4:0];
                m_drop = (f[4:0] >= NOSC);
            end
            2'b01: begin
                if (m_hdr && !m_body) begin
                    m_body = 1; m_hi = f[15:0];
                end else begin
                    bump(); m_hdr = 0; m_body = 0;
                end
            end
            2'b11: begin
                if (m_hdr && m_body) begin
                    if (!m_drop) begin
                        m_pend = 1; m_addr = {m_src, m_osc}; m_data = {m_hi, f[7:0]};
                    end
                end else begin
                    bump();
                end
                m_hdr = 0; m_body = 0;
            end
            default: begin
                bump(); m_hdr = 0; m_body = 0;
            end
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hdr = 0; m_body = 0; m_drop = 0; m_pend = 0; m_fd = 0;
            m_src = '0; m_fsrc = '0; m_osc = '0; m_hi = '0; m_addr = '0; m_data = '0; m_err = 0;
        end else begin
            m_fd = 0;
            if (m_pend) begin
                if (WrReady_i) begin
                    m_pend = 0;
                    if (m_addr[4:0] == 5'(NOSC - 1)) begin
                        m_fd = 1; m_fsrc = m_addr[8:5];
                    end
                end
            end else if (!FifoEmpty_i) begin
                model_flit(FifoRdData_i);
            end
            if (rd_seen && fifo_q.size() != 0) void'(fifo_q.pop_front());
        end
    end

    always @(posedge clk) begin
        #1;
        FifoEmpty_i  = (fifo_q.size() == 0);
        FifoRdData_i = (fifo_q.size() != 0) ? fifo_q[0] : $urandom();
        WrReady_i    = !rdy_hold && ($urandom_range(0, 99) < rdy_pct);
    end

    always @(negedge clk) begin
        rd_seen = FifoRd_o;
        chk("fifo_rd", FifoRd_o, !FifoEmpty_i && !m_pend);
        chk("wr", Wr_o, m_pend);
        if (m_pend) begin
            chk("wr_addr", WrAddr_o, m_addr);
            chk("wr_data", WrData_o, m_data);
        end
        chk("err_cnt", ErrCnt_o, m_err);
        chk("frame_done", FrameDone_o, m_fd);
        chk("frame_src", FrameSrc_o, m_fsrc);
        chk("busy", Busy_o, m_pend || m_hdr);
        if (rst) begin
            chk("rst_addr", WrAddr_o, 0);
            chk("rst_data", WrData_o, 0);
        end
        if (Wr_o) wr_cyc++;
        if (Wr_o && WrReady_i) wr_log.push_back({WrAddr_o, WrData_o});
        if (FrameDone_o) begin
            fd_cnt++; last_fsrc = FrameSrc_o;
        end
    end

    function automatic logic [31:0] head(input logic [3:0] s, input logic [4:0] o);
        return {2'b00, 21'd0, s, o};
    endfunction
    function automatic logic [31:0] body(input logic [15:0] d);
        return {2'b01, 14'd0, d};
    endfunction
    function automatic logic [31:0] tail(input logic [7:0] d);
        return {2'b11, 22'd0, d};
    endfunction

    task automatic pkt(input logic [3:0] s, input logic [4:0] o, input logic [23:0] d);
        fifo_q.push_back(head(s, o));
        fifo_q.push_back(body(d[23:8]));
        fifo_q.push_back(tail(d[7:0]));
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((fifo_q.size() != 0 || m_pend) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) begin
            n_checks++; n_errors++;
            $display("FAIL idle_timeout: still busy after %0d cycles", budget);
        end
        repeat (3) @(posedge clk);
    endtask

    int wr_base, fd_base, cyc_base;

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        fifo_q.delete();
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        wr_base  = wr_log.size();
        fd_base  = fd_cnt;
        cyc_base = wr_cyc;
    endtask

    logic [23:0] sweep_d[NOSC];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; FifoEmpty_i = 1'b1; FifoRdData_i = '0; WrReady_i = 1'b0;
        @(negedge clk);
        chk("reset_wr", Wr_o, 0);
        chk("reset_busy", Busy_o, 0);
        chk("reset_err", ErrCnt_o, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Single packet
        do_reset();
        pkt(4'd3, 5'd7, 24'hABCDEF);
        wait_idle(50);
        chk("single_count", wr_log.size() - wr_base, 1);
        chk("single_addr", wr_log[wr_base][32:24], 9'h067);
        chk("single_data", wr_log[wr_base][23:0], 24'hABCDEF);
        chk("single_wr_cycles", wr_cyc - cyc_base, 1);
        chk("single_err", ErrCnt_o, 0);

        // Full sweep
        do_reset();
        for (int i = 0; i < NOSC; i++) begin
            sweep_d[i] = 24'($urandom());
            pkt(4'd5, 5'(i), sweep_d[i]);
        end
        wait_idle(500);
        chk("sweep_count", wr_log.size() - wr_base, NOSC);
        for (int i = 0; i < NOSC; i++) begin
            chk("sweep_addr", wr_log[wr_base + i][32:24], {4'd5, 5'(i)});
            chk("sweep_data", wr_log[wr_base + i][23:0], sweep_d[i]);
        end
        chk("sweep_fd_count", fd_cnt - fd_base, 1);
        chk("sweep_fd_src", last_fsrc, 4'd5);

        // Backpressure
        do_reset();
        rdy_hold = 1'b1;
        pkt(4'd2, 5'd3, 24'h111111);
        fifo_q.push_back(head(4'd2, 5'd4));
        repeat (14) @(posedge clk);
        @(negedge clk);
        chk("bp_wr_held", Wr_o, 1);
        chk("bp_addr_held", WrAddr_o, 9'h043);
        chk("bp_no_pop", FifoRd_o, 0);
        chk("bp_no_write_yet", wr_log.size() - wr_base, 0);
        rdy_hold = 1'b0;
        fifo_q.push_back(body(16'h2222));
        fifo_q.push_back(tail(8'h22));
        wait_idle(100);
        chk("bp_count", wr_log.size() - wr_base, 2);
        chk("bp_addr0", wr_log[wr_base][32:24], 9'h043);
        chk("bp_data0", wr_log[wr_base][23:0], 24'h111111);
        chk("bp_addr1", wr_log[wr_base + 1][32:24], 9'h044);

        // Protocol errors
        do_reset();
        fifo_q.push_back(tail(8'h99));
        fifo_q.push_back(head(4'd1, 5'd2));
        fifo_q.push_back(head(4'd1, 5'd4));
        fifo_q.push_back(body(16'h1234));
        fifo_q.push_back(tail(8'h56));
        wait_idle(100);
        chk("proto_err", ErrCnt_o, 2);
        chk("proto_count", wr_log.size() - wr_base, 1);
        chk("proto_addr", wr_log[wr_base][32:24], 9'h024);
        chk("proto_data", wr_log[wr_base][23:0], 24'h123456);
        fifo_q.push_back(head(4'd1, 5'd5));
        fifo_q.push_back(32'h8000_0000);
        wait_idle(100);
        chk("illegal_err", ErrCnt_o, 3);
        chk("illegal_no_write", wr_log.size() - wr_base, 1);

        // Out-of-range oscillator index
        do_reset();
        pkt(4'd6, 5'd25, 24'h777777);
        pkt(4'd6, 5'd1, 24'h010203);
        wait_idle(100);
        chk("oob_err", ErrCnt_o, 1);
        chk("oob_count", wr_log.size() - wr_base, 1);
        chk("oob_addr", wr_log[wr_base][32:24], 9'h0C1);
        chk("oob_data", wr_log[wr_base][23:0], 24'h010203);

        // Randomized traffic with random backpressure
        do_reset();
        rdy_pct = 70;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 7)
                pkt(4'($urandom()), 5'($urandom()), 24'($urandom()));
            else
                fifo_q.push_back($urandom());
            if (fifo_q.size() > 16) wait_idle(400);
        end
        wait_idle(400);
        rdy_pct = 100;

        // Error counter saturation
        do_reset();
        for (int i = 0; i < 300; i++) fifo_q.push_back(32'h8000_0000);
        wait_idle(1000);
        chk("sat_err", ErrCnt_o, 255);

        // Reset mid-packet
        do_reset();
        fifo_q.push_back(head(4'd4, 5'd9));
        fifo_q.push_back(body(16'hBEEF));
        wait_idle(50);
        do_reset();
        fifo_q.push_back(tail(8'h11));
        pkt(4'd4, 5'd10, 24'h445566);
        wait_idle(100);
        chk("rstmid_err", ErrCnt_o, 1);
        chk("rstmid_count", wr_log.size() - wr_base, 1);
        chk("rstmid_addr", wr_log[wr_base][32:24], 9'h08A);
        chk("rstmid_data", wr_log[wr_base][23:0], 24'h445566);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
